// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, imem request handshake and branch/jump next-PC selection.
// Optional macro IMEM_TIMEOUT_EN adds a 16-cycle ack timeout with a sticky fetch_err and an ERR state.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        jump,
  input  logic        alu_zero,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_target,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1
`ifdef IMEM_TIMEOUT_EN
    , S_ERR = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        taken_s;
  logic [31:0] next_pc_s;
`ifdef IMEM_TIMEOUT_EN
  logic [3:0]  cnt_q, cnt_d;
  logic        fetch_err_q, fetch_err_d;
`endif

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q;
  // The request is masked while reset is asserted so the abandoned fetch never reaches memory.
  assign imem_req    = rst_n & (state_q == S_REQ);
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign instr_valid = instr_valid_q;
`ifdef IMEM_TIMEOUT_EN
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Next-PC selection: jump beats a taken branch, which beats sequential flow.
  always_comb begin
    taken_s = (branch & alu_zero) | (branch_ne & ~alu_zero);
    if (jump) begin
      next_pc_s = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (taken_s) begin
      next_pc_s = pc_plus4 + (branch_offset << 2);
    end else begin
      next_pc_s = pc_plus4;
    end
  end

  // FSM next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
`ifdef IMEM_TIMEOUT_EN
    cnt_d         = cnt_q;
    fetch_err_d   = fetch_err_q;
`endif
    case (state_q)
      S_REQ: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_VALID;
        end else begin
`ifdef IMEM_TIMEOUT_EN
          if (cnt_q == 4'd15) begin
            state_d     = S_ERR;
            fetch_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
`else
          state_d = S_REQ;
`endif
        end
      end
      S_VALID: begin
        if (!stall) begin
          pc_d          = next_pc_s & 32'hFFFF_FFFC;
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
`ifdef IMEM_TIMEOUT_EN
          cnt_d         = 4'd0;
`endif
        end else begin
          state_d = S_VALID;
        end
      end
`ifdef IMEM_TIMEOUT_EN
      S_ERR: begin
        state_d       = S_ERR;
        instr_valid_d = 1'b0;
      end
`endif
      default: begin
        state_d       = S_REQ;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC & 32'hFFFF_FFFC;
      instr_q       <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
`ifdef IMEM_TIMEOUT_EN
      cnt_q         <= 4'd0;
      fetch_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
`ifdef IMEM_TIMEOUT_EN
      cnt_q         <= cnt_d;
      fetch_err_q   <= fetch_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a stimulus process feeds a reference model that queues
// expected fetch addresses and instructions; a negedge monitor pops and compares them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic [31:0] pc_plus4;
  logic        stall = 1'b0, branch = 1'b0, branch_ne = 1'b0, jump = 1'b0, alu_zero = 1'b0;
  logic [31:0] branch_offset = 32'h0;
  logic [25:0] jump_target = 26'h0;
  logic        fetch_err;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .op(op),
    .instr_valid(instr_valid), .pc_plus4(pc_plus4), .stall(stall), .branch(branch),
    .branch_ne(branch_ne), .jump(jump), .alu_zero(alu_zero), .branch_offset(branch_offset),
    .jump_target(jump_target), .fetch_err(fetch_err)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];

  // Reference model state: current PC, whether an instruction is held, unacked streak, error.
  logic [31:0] m_pc;
  bit          m_hold;
  int          m_miss;
  bit          m_err;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(logic [31:0] pc, bit j, bit b, bit bne, bit z,
                                           logic [31:0] off, logic [25:0] tgt);
    logic [31:0] p4;
    logic [31:0] top;
    p4 = pc + 32'd4;
    if (j) begin
      top = p4 & 32'hF000_0000;
      return top + ({6'd0, tgt} * 32'd4);
    end
    if ((b && z) || (bne && !z)) return p4 + off * 32'd4;
    return p4;
  endfunction

  // Monitor: a rising imem_req presents a new fetch address, a rising instr_valid a new instruction.
  logic prev_req = 1'b0, prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (imem_req && !prev_req) begin
      if (exp_addr_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_request: got addr %h expected no request", imem_addr);
      end else begin
        e = exp_addr_q.pop_front();
        chk("imem_addr", imem_addr, e);
        chk("pc_plus4", pc_plus4, e + 32'd4);
      end
    end
    if (instr_valid && !prev_valid) begin
      if (exp_instr_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_instr: got %h expected no instruction", instr);
      end else begin
        e = exp_instr_q.pop_front();
        chk("instr", instr, e);
        chk("op", {26'd0, op}, {26'd0, e[31:26]});
      end
    end
    prev_req   = imem_req;
    prev_valid = instr_valid;
  end

  task automatic step(bit ack, logic [31:0] rd, bit st, bit j, bit b, bit bne, bit z,
                      logic [31:0] off, logic [25:0] tgt);
    imem_ack = ack; imem_rdata = rd; stall = st; jump = j; branch = b;
    branch_ne = bne; alu_zero = z; branch_offset = off; jump_target = tgt;
    @(posedge clk);
    if (!m_err) begin
      if (!m_hold) begin
        if (ack) begin
          exp_instr_q.push_back(rd);
          m_hold = 1'b1;
          m_miss = 0;
        end else begin
          m_miss++;
`ifdef IMEM_TIMEOUT_EN
          if (m_miss == 16) m_err = 1'b1;
`endif
        end
      end else if (!st) begin
        m_pc = ref_next(m_pc, j, b, bne, z, off, tgt);
        m_hold = 1'b0;
        m_miss = 0;
        exp_addr_q.push_back(m_pc);
      end
    end
    #2;
  endtask

  task automatic plain(bit ack);
    step(ack, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", imem_addr, 32'h0);
    exp_addr_q.delete();
    exp_instr_q.delete();
    m_pc = 32'h0; m_hold = 1'b0; m_miss = 0; m_err = 1'b0;
    imem_ack = 1'b1;
    @(posedge clk); #2;
    chk("rst_hold_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b0;
    exp_addr_q.push_back(32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] held_instr, held_addr;
    logic [15:0] r16;
    bit          ack_r;

    do_reset();

    // First fetch returns an addi-like word.
    step(1'b1, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_op", {26'd0, op}, 32'd8);

    // Back-to-back acks: instr_valid alternates, addresses 4 then 8.
    for (int k = 0; k < 4; k++) begin
      plain(1'b1);
      chk("toggle_valid", {31'd0, instr_valid}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end

    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 26'h0);
    chk("beq_taken", imem_addr, 32'h4);
    plain(1'b1); plain(1'b1); plain(1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0);
    chk("beq_not_taken", imem_addr, 32'hC);
    plain(1'b1);

    // Wrap to the top of the address space and back to zero.
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFB, 26'h0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    plain(1'b1);
    plain(1'b1);
    chk("wrap_seq", imem_addr, 32'h0);
    plain(1'b1);

    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0400_0003, 26'h0);
    chk("far_branch", imem_addr, 32'h1000_0010);
    plain(1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 26'h000_0040);
    chk("jump_priority", imem_addr, 32'h1000_0100);
    plain(1'b1);

    // Stall with changing controls, then release with the final controls.
    held_instr = instr;
    for (int k = 0; k < 3; k++) begin
      step($urandom_range(0, 1), $urandom, 1'b1, $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom);
      chk("stall_instr", instr, held_instr);
      chk("stall_pc", imem_addr, 32'h1000_0100);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3, 26'h3FF_FFFF);
    chk("stall_release", imem_addr, 32'h1000_0110);
    plain(1'b1);

    // Randomized traffic, with a reset dropped into the middle.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      ack_r = (m_miss >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
      r16 = 16'($urandom);
      step(ack_r, $urandom, ($urandom_range(0, 9) < 3), $urandom_range(0, 3) == 0,
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           {{16{r16[15]}}, r16}, 26'($urandom));
    end

    // Memory that never answers.
    do_reset();
    held_addr = imem_addr;
`ifdef IMEM_TIMEOUT_EN
    for (int k = 0; k < 15; k++) plain(1'b0);
    chk("timeout_early", {31'd0, fetch_err}, 32'd0);
    chk("timeout_req_early", {31'd0, imem_req}, 32'd1);
    plain(1'b0);
    chk("timeout_err", {31'd0, fetch_err}, 32'd1);
    chk("timeout_req", {31'd0, imem_req}, 32'd0);
    chk("timeout_valid", {31'd0, instr_valid}, 32'd0);
    for (int k = 0; k < 3; k++) plain(1'b1);
    chk("timeout_sticky", {31'd0, fetch_err}, 32'd1);
    chk("timeout_sticky_valid", {31'd0, instr_valid}, 32'd0);
    do_reset();
`else
    for (int k = 0; k < 100; k++) plain(1'b0);
    chk("idle_req", {31'd0, imem_req}, 32'd1);
    chk("idle_err", {31'd0, fetch_err}, 32'd0);
    chk("idle_addr", imem_addr, held_addr);
`endif
    plain(1'b1);
    plain(1'b1);
    plain(1'b1);

    @(negedge clk); #1;
    chk("addr_queue_drained", exp_addr_q.size(), 32'd0);
    chk("instr_queue_drained", exp_instr_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
